mem_port_arbiter: RTL

- Shares the single unified memory port between the instruction-fetch stage (IF) and the data-memory stage (MEM) of the 5-stage pipeline.
- Sequences each access through a fixed-latency memory.
- Returns data and a one-cycle ready pulse to the owning stage.
- Drives stall_if and stall_mem into the hazard unit, so that unit freezes PC/IF or the back end while a stage waits for the port.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and data access.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP against a fixed-latency memory.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          owner_d;
    logic [2:0]    lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_d;

    // Data wins a tie until IF has been passed over STARVE_MAX times.
    always_comb begin
        grant_d = d_req & (~if_req | (starve_cnt < SW'(STARVE_MAX)));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (if_req && grant_d) begin
                        if (starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (if_req || d_req) begin
                        owner_d  <= grant_d;
                        mem_en   <= 1'b1;
                        mem_we   <= grant_d & d_we;
                        mem_addr <= grant_d ? d_addr : if_addr;
                        if (grant_d)
                            mem_wdata <= d_wdata;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= 3'(MEM_LAT - 1);
                    state   <= (MEM_LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1)
                        state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        if_ready  = (state == RESP) & ~owner_d;
        d_ready   = (state == RESP) & owner_d;
        if_rdata  = if_ready ? mem_rdata : '0;
        d_rdata   = d_ready ? mem_rdata : '0;
        stall_if  = if_req & ~if_ready;
        stall_mem = d_req & ~d_ready;
    end

endmodule
